// File: rtl/inst_queue.sv
// inst_queue: instruction queue between fetch and decode.
//
// Accepts one 8-byte-aligned fetch packet (two 32-bit instructions) per cycle
// and stores each instruction with its PC in a circular buffer of DEPTH
// entries. The two oldest entries are presented to decode, which consumes
// 0, 1 or 2 of them per cycle.
//
// Build option: define INST_QUEUE_BYPASS_EN to forward an incoming packet
// straight to the id_* outputs when the queue is empty.
//
// Ports:
//   clk             clock, all state updates on rising edge
//   rst             synchronous reset, active-low
//   flush           discard all entries (overrides push and pop)
//   fetch_valid     fetch packet valid
//   fetch_pc        fetch PC; bit 2 set means only the upper instruction is used
//   fetch_inst      {inst at pc+4, inst at pc+0}
//   stallreq_fetch  fewer than 2 free entries; fetch must hold
//   id_pop          instructions consumed by decode (3 treated as 2)
//   id_valid0/1     slot valid (slot 0 = oldest)
//   id_pc0/1        slot PC
//   id_inst0/1      slot instruction
module inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [63:0] fetch_inst,
  output logic        stallreq_fetch,
  input  logic [1:0]  id_pop,
  output logic        id_valid0,
  output logic        id_valid1,
  output logic [31:0] id_pc0,
  output logic [31:0] id_pc1,
  output logic [31:0] id_inst0,
  output logic [31:0] id_inst1
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic [PW-1:0] rd_ptr1, wr_ptr1;
  logic [CW-1:0] free_n;
  logic          push;
  logic [1:0]    pop_req;
  logic [1:0]    in_n;
  logic [31:0]   in_pc0, in_pc1, in_inst0, in_inst1;
  logic [1:0]    rd_n, wr_n;
  logic          wr_skip;

  assign rd_ptr1        = rd_ptr + PW'(1);
  assign wr_ptr1        = wr_ptr + PW'(1);
  assign free_n         = CW'(DEPTH) - count;
  assign stallreq_fetch = free_n < CW'(2);
  assign push           = fetch_valid & ~stallreq_fetch & ~flush;
  assign pop_req        = (id_pop == 2'd3) ? 2'd2 : id_pop;

  // Packet split into up to two entries in program order; entry 0 is always
  // written first. fetch_pc[1:0] is zero by contract, so carrying it through
  // is equivalent to forcing the low bits.
  always_comb begin
    in_pc1   = '0;
    in_inst1 = '0;
    if (fetch_pc[2]) begin
      in_n     = 2'd1;
      in_pc0   = {fetch_pc[31:3], 1'b1, fetch_pc[1:0]};
      in_inst0 = fetch_inst[63:32];
    end else begin
      in_n     = 2'd2;
      in_pc0   = {fetch_pc[31:3], 1'b0, fetch_pc[1:0]};
      in_inst0 = fetch_inst[31:0];
      in_pc1   = {fetch_pc[31:3], 1'b1, fetch_pc[1:0]};
      in_inst1 = fetch_inst[63:32];
    end
  end

  // Pop/write accounting and decode-side outputs.
  always_comb begin
    logic        v0, v1;
    logic [31:0] pc0, pc1, inst0, inst1;

    rd_n    = (CW'(pop_req) > count) ? count[1:0] : pop_req;
    wr_n    = push ? in_n : 2'd0;
    wr_skip = 1'b0;

    v0    = (count != '0);
    v1    = (count >= CW'(2));
    pc0   = mem_pc[rd_ptr];
    inst0 = mem_inst[rd_ptr];
    pc1   = mem_pc[rd_ptr1];
    inst1 = mem_inst[rd_ptr1];

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: forward the packet and store only what decode leaves.
    if (push && (count == '0)) begin
      logic [1:0] byp_pop;
      byp_pop = (pop_req > in_n) ? in_n : pop_req;
      rd_n    = 2'd0;
      wr_n    = in_n - byp_pop;
      wr_skip = (byp_pop != 2'd0);
      v0      = 1'b1;
      v1      = (in_n == 2'd2);
      pc0     = in_pc0;
      inst0   = in_inst0;
      pc1     = in_pc1;
      inst1   = in_inst1;
    end
    if (flush) begin
      v0 = 1'b0;
      v1 = 1'b0;
    end
`endif

    id_valid0 = v0;
    id_valid1 = v1;
    id_pc0    = v0 ? pc0   : '0;
    id_inst0  = v0 ? inst0 : '0;
    id_pc1    = v1 ? pc1   : '0;
    id_inst1  = v1 ? inst1 : '0;
  end

  // Storage has no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) begin
      mem_pc[wr_ptr]   <= wr_skip ? in_pc1   : in_pc0;
      mem_inst[wr_ptr] <= wr_skip ? in_inst1 : in_inst0;
    end
    if (wr_n == 2'd2) begin
      mem_pc[wr_ptr1]   <= in_pc1;
      mem_inst[wr_ptr1] <= in_inst1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(rd_n);
      wr_ptr <= wr_ptr + PW'(wr_n);
      count  <= count + CW'(wr_n) - CW'(rd_n);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed + pseudo-random bench for inst_queue (default build, no bypass).
// A reference queue holds the expected {pc, inst} entries in program order;
// entries are appended when a packet is accepted and removed when decode pops.
module tb_inst_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_inst;
  logic        stallreq_fetch;
  logic [1:0]  id_pop;
  logic        id_valid0, id_valid1;
  logic [31:0] id_pc0, id_pc1, id_inst0, id_inst1;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [63:0] sb[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .stallreq_fetch (stallreq_fetch),
    .id_pop         (id_pop),
    .id_valid0      (id_valid0),
    .id_valid1      (id_valid1),
    .id_pc0         (id_pc0),
    .id_pc1         (id_pc1),
    .id_inst0       (id_inst0),
    .id_inst1       (id_inst1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue (called at negedge).
  task automatic check_outputs(input string tag);
    logic [63:0] e0, e1;
    e0 = (sb.size() >= 1) ? sb[0] : 64'd0;
    e1 = (sb.size() >= 2) ? sb[1] : 64'd0;
    chk({tag, ".valid0"}, 64'(id_valid0), 64'(sb.size() >= 1));
    chk({tag, ".valid1"}, 64'(id_valid1), 64'(sb.size() >= 2));
    chk({tag, ".slot0"},  {id_pc0, id_inst0}, e0);
    chk({tag, ".slot1"},  {id_pc1, id_inst1}, e1);
    chk({tag, ".stall"},  64'(stallreq_fetch), 64'((DEPTH - sb.size()) < 2));
  endtask

  // One clock: check current outputs, drive inputs, advance, update model.
  task automatic step(input string tag, input logic fl, input logic fv,
                      input logic [31:0] pc, input logic [63:0] inst,
                      input logic [1:0] pop);
    bit mstall;
    int p;
    check_outputs(tag);
    flush       = fl;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_inst  = inst;
    id_pop      = pop;
    mstall = (DEPTH - sb.size()) < 2;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      p = (pop == 2'd3) ? 2 : int'(pop);
      if (p > sb.size()) p = sb.size();
      repeat (p) void'(sb.pop_front());
      if (fv && !mstall) begin
        if (!pc[2]) sb.push_back({pc[31:3], 3'b000, inst[31:0]});
        sb.push_back({pc[31:3], 3'b100, inst[63:32]});
      end
    end
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    id_pop      = 2'd0;
  endtask

  initial begin
    logic [31:0] rpc;
    logic [63:0] rinst;

    // Reset with junk on the fetch port: nothing may be captured.
    rst         = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h1234_5670;
    fetch_inst  = 64'hdead_beef_cafe_f00d;
    id_pop      = 2'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst         = 1'b1;
    fetch_valid = 1'b0;
    id_pop      = 2'd0;

    // Reset and fill.
    step("reset", 0, 1, 32'hbfc0_0000, {32'h2, 32'h1}, 2'd0);
    step("fill1", 0, 1, 32'hbfc0_0008, {32'h4, 32'h3}, 2'd0);
    // Full: two more packets bring count to 8, a fifth is refused.
    step("fill2", 0, 1, 32'hbfc0_0010, {32'h6, 32'h5}, 2'd0);
    step("fill3", 0, 1, 32'hbfc0_0018, {32'h8, 32'h7}, 2'd0);
    step("full",  0, 1, 32'hbfc0_0020, {32'hA, 32'h9}, 2'd0);
    step("fullpop", 0, 0, 32'h0, 64'h0, 2'd2);
    step("unstall", 0, 0, 32'h0, 64'h0, 2'd2);
    step("drain1",  0, 0, 32'h0, 64'h0, 2'd3);
    step("drain2",  0, 0, 32'h0, 64'h0, 2'd2);

    // Mid-packet branch target into an empty queue.
    step("empty", 0, 1, 32'h8000_0104, {32'hBBBB, 32'hAAAA}, 2'd0);
    step("mid",   0, 0, 32'h0, 64'h0, 2'd1);

    // Walk pointers to rd=7, count=1, then push+pop across the wrap.
    step("w1", 0, 1, 32'h0000_1000, {32'h11, 32'h10}, 2'd0);
    step("w2", 0, 1, 32'h0000_1008, {32'h13, 32'h12}, 2'd2);
    step("w3", 0, 1, 32'h0000_1010, {32'h15, 32'h14}, 2'd2);
    step("w4", 0, 1, 32'h0000_101c, {32'h17, 32'h16}, 2'd1);
    step("w5", 0, 0, 32'h0, 64'h0, 2'd1);
    step("wrap", 0, 1, 32'h0000_2000, {32'h21, 32'h20}, 2'd1);
    step("wrap2", 0, 0, 32'h0, 64'h0, 2'd0);

    // Flush priority with count=5 plus a valid packet and a pop.
    step("pf1", 0, 1, 32'h0000_3000, {32'h31, 32'h30}, 2'd0);
    step("pf2", 0, 1, 32'h0000_3004, {32'h33, 32'h32}, 2'd0);
    step("flush", 1, 1, 32'h0000_3008, {32'h35, 32'h34}, 2'd2);
    step("postflush", 0, 0, 32'h0, 64'h0, 2'd0);

    // Over-pop on a single entry, then normal read-back.
    step("op1", 0, 1, 32'h0000_4004, {32'h41, 32'h40}, 2'd0);
    step("overpop", 0, 0, 32'h0, 64'h0, 2'd2);
    step("op2", 0, 1, 32'h0000_4008, {32'h43, 32'h42}, 2'd0);
    step("op3", 0, 0, 32'h0, 64'h0, 2'd0);

    // Mixed traffic to exercise wrap, straddled pairs and stall at all levels.
    for (int i = 0; i < 200; i++) begin
      rpc   = {$urandom, 3'b000};
      rpc[2] = $urandom_range(0, 3) == 0;
      rinst = {$urandom, $urandom};
      step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           rpc, rinst, 2'($urandom_range(0, 3)));
    end
    step("drainA", 0, 0, 32'h0, 64'h0, 2'd2);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 32'h0, 64'h0, 2'd2);
    check_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
